// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares one asynchronous video SRAM between an ISA host port and a pixel
// fetch port. Host writes are posted into a small queue and drained into
// the RAM by a three-state FSM (IDLE/SETUP/STROBE) whenever the RAM is
// free. Host reads are served from the RAM or forwarded from the newest
// queued write to the same address.
//
// Optional feature: define VRAM_SNOW_EN to load all-ones into pixel_data
// whenever the pixel port requests data but does not own the RAM (CGA
// "snow"). With the macro undefined, pixel_data holds on such cycles.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   isa_addr/din/dout     host address, write data, read data (dout comb.)
//   isa_read, isa_write   host read strobe (level), write strobe (edge)
//   isa_ready             high when the host may complete its cycle
//   pixel_addr/read/data  pixel fetch address, request, registered data
//   ram_a/din/d           RAM address, read data, write data
//   ram_ce_l/oe_l/we_l    RAM controls, active-low
//   wq_overflow           sticky: a posted write was dropped (queue full)
module vram_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 8,
  parameter int WQ_DEPTH  = 4,
  parameter int DIN_DELAY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] isa_addr,
  input  logic [DATA_W-1:0] isa_din,
  output logic [DATA_W-1:0] isa_dout,
  input  logic              isa_read,
  input  logic              isa_write,
  output logic              isa_ready,
  input  logic [ADDR_W-1:0] pixel_addr,
  input  logic              pixel_read,
  output logic [DATA_W-1:0] pixel_data,
  output logic [ADDR_W-1:0] ram_a,
  input  logic [DATA_W-1:0] ram_din,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_ce_l,
  output logic              ram_oe_l,
  output logic              ram_we_l,
  output logic              wq_overflow
);

  localparam int PTR_W = $clog2(WQ_DEPTH);
  localparam int CNT_W = $clog2(WQ_DEPTH) + 1;
  localparam int DLY_W = 3;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(WQ_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(WQ_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [DLY_W-1:0] DLY_ZERO   = {DLY_W{1'b0}};
  localparam logic [DLY_W-1:0] DLY_ONE    = {{(DLY_W-1){1'b0}}, 1'b1};
  localparam logic [DLY_W-1:0] DLY_LOAD   = DLY_W'(DIN_DELAY);

`ifdef VRAM_SNOW_EN
  localparam logic SNOW = 1'b1;
`else
  localparam logic SNOW = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } state_t;

  state_t            state;

  logic [ADDR_W-1:0] wq_addr [WQ_DEPTH];
  logic [DATA_W-1:0] wq_data [WQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              prev_write;
  logic [DLY_W-1:0]  dly_cnt;
  logic [ADDR_W-1:0] pend_addr;

  logic              write_edge;
  logic              dly_running;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              full;
  logic              empty;
  logic              start_drain;
  logic              pixel_owns;

  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  fwd_idx;
  logic              fwd_match;

  assign ram_ce_l = 1'b0;
  assign ram_oe_l = 1'b0;

  // Control decode shared by the capture, queue and drain logic.
  always_comb begin
    write_edge  = isa_write & ~prev_write;
    dly_running = (dly_cnt != DLY_ZERO);
    // A fresh write edge restarts the delay, so the pending write never commits.
    push_req    = dly_running & (dly_cnt == DLY_ONE) & ~write_edge;
    full        = (count == CNT_FULL);
    empty       = (count == CNT_ZERO);
    pop         = (state == STROBE);
    // A pop in the same cycle frees the slot the push needs.
    push_ok     = push_req & (~full | pop);
    // A full queue forces a drain even while the pixel port is fetching.
    start_drain = (state == IDLE) & ~empty & ~isa_read & (~pixel_read | full);
    pixel_owns  = (state == IDLE) & ~isa_read;
  end

  // RAM address mux: queue head while draining, otherwise host read or pixel fetch.
  always_comb begin
    ram_a = pixel_addr;
    if (state != IDLE) begin
      ram_a = wq_addr[rd_ptr];
    end else if (isa_read) begin
      ram_a = isa_addr;
    end else begin
      ram_a = pixel_addr;
    end
  end

  // Read forwarding: walk oldest to newest so the newest matching entry wins.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_data  = {DATA_W{1'b0}};
    fwd_idx   = PTR_ZERO;
    fwd_match = 1'b0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      fwd_idx   = rd_ptr + PTR_W'(i);
      fwd_match = (CNT_W'(i) < count) && (wq_addr[fwd_idx] == isa_addr);
      fwd_hit   = fwd_match ? 1'b1 : fwd_hit;
      fwd_data  = fwd_match ? wq_data[fwd_idx] : fwd_data;
    end
    isa_dout = fwd_hit ? fwd_data : ram_din;
  end

  // Host handshake: stall reads behind a drain or an uncommitted write, and
  // stall everything once only one free slot is left.
  always_comb begin
    isa_ready = ~((isa_read & ((state != IDLE) | dly_running)) | (count >= CNT_ALMOST));
  end

  // Write-strobe edge detect, address capture and data-sample delay counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_write <= 1'b0;
      dly_cnt    <= DLY_ZERO;
      pend_addr  <= {ADDR_W{1'b0}};
    end else begin
      prev_write <= isa_write;
      if (write_edge) begin
        dly_cnt   <= DLY_LOAD;
        pend_addr <= isa_addr;
      end else if (dly_running) begin
        dly_cnt <= dly_cnt - DLY_ONE;
      end else begin
        dly_cnt <= dly_cnt;
      end
    end
  end

  // Queue pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= PTR_ZERO;
      rd_ptr      <= PTR_ZERO;
      count       <= CNT_ZERO;
      wq_overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push_req && !push_ok) begin
        wq_overflow <= 1'b1;
      end
    end
  end

  // Queue storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      wq_addr[wr_ptr] <= pend_addr;
      wq_data[wr_ptr] <= isa_din;
    end
  end

  // Drain FSM with registered write strobe and write data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ram_we_l <= 1'b1;
      ram_d    <= {DATA_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (start_drain) begin
            state <= SETUP;
            ram_d <= wq_data[rd_ptr];
          end
        end
        SETUP: begin
          state    <= STROBE;
          ram_we_l <= 1'b0;
        end
        STROBE: begin
          state    <= IDLE;
          ram_we_l <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          ram_we_l <= 1'b1;
        end
      endcase
    end
  end

  // Pixel fetch register: one-cycle latency when the pixel port owns the RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_data <= {DATA_W{1'b0}};
    end else if (pixel_read && pixel_owns) begin
      pixel_data <= ram_din;
    end else if (pixel_read && SNOW) begin
      pixel_data <= {DATA_W{1'b1}};
    end else begin
      pixel_data <= pixel_data;
    end
  end

endmodule
